// File: rtl/dct_pass_sched.sv
// dct_pass_sched: time-shares one 1D DCT engine between the row pass and the
// column pass of an 8x8 2D DCT, using a ping-pong transpose store of two banks.
module dct_pass_sched #(
   parameter int LAT = 8,   // fixed latency of the shared 1D engine, in cycles
   parameter int W   = 16   // sample width
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [7:0][W-1:0] in_data,
   input  logic              in_sof,
   output logic              eng_valid,
   output logic [7:0][W-1:0] eng_data,
   input  logic [7:0][W-1:0] eng_res,
   output logic              out_valid,
   output logic [7:0][W-1:0] out_data,
   output logic              out_sob,
   output logic              out_eob,
   output logic              out_sof
);

   typedef logic [7:0][W-1:0] vec_t;

   typedef enum logic [1:0] {FREE, FILL, FULL, DRAIN} bank_st_e;

   // One in-flight engine operation; travels alongside the engine latency.
   typedef struct packed {
      logic       valid;
      logic       is_col;
      logic       bank;
      logic [2:0] idx;
      logic       sof;
   } tag_t;

   bank_st_e         bank_st [2];
   bank_st_e         bank_nx [2];
   logic             wr_ptr;
   logic             rd_ptr;
   logic [2:0]       row_cnt;
   logic [2:0]       col_cnt;
   vec_t             mem [2][8];
   logic             bank_sof [2];
   tag_t [LAT-1:0]   tag_q;
   tag_t             tag_new;
   tag_t             tag_ret;
   vec_t             eng_data_q;
   vec_t             col_vec;
   logic             col_issue;
   logic             row_issue;
   logic             wr_open;
   logic             row_ret;
   logic             col_ret;

   assign tag_ret = tag_q[LAT-1];
   assign row_ret = tag_ret.valid && !tag_ret.is_col;
   assign col_ret = tag_ret.valid && tag_ret.is_col;

   // Arbitration, engine operand mux and the tag launched with each issue.
   always_comb begin : issue_arb
      // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
      tag_new   = '0;
      col_vec   = '0;
      // Columns drain whenever the read bank holds a complete block.
      col_issue = (bank_st[rd_ptr] == FULL) || (bank_st[rd_ptr] == DRAIN);
      // A FILL bank with row_cnt back at 0 has already had all 8 rows issued.
      wr_open   = (bank_st[wr_ptr] == FREE) ||
                  ((bank_st[wr_ptr] == FILL) && (row_cnt != 3'd0));
      in_ready  = !col_issue && wr_open;
      // Nothing may reach the engine while reset is held.
      row_issue = in_valid && in_ready && rst_n;
      for (int i = 0; i < 8; i++) begin
         col_vec[i] = mem[rd_ptr][i][col_cnt];
      end
      eng_valid = row_issue || col_issue;
      eng_data  = eng_data_q;
      if (col_issue) begin
         eng_data = col_vec;
      end else if (row_issue) begin
         eng_data = in_data;
      end
      tag_new.valid  = eng_valid;
      tag_new.is_col = col_issue;
      tag_new.bank   = col_issue ? rd_ptr : wr_ptr;
      tag_new.idx    = col_issue ? col_cnt : row_cnt;
      tag_new.sof    = col_issue ? bank_sof[rd_ptr] : in_sof;
   end

   // Per-bank FREE -> FILL -> FULL -> DRAIN -> FREE next-state logic.
   always_comb begin : bank_next
      for (int b = 0; b < 2; b++) begin
         bank_nx[b] = bank_st[b];
         case (bank_st[b])
            FREE:  if (row_issue && (wr_ptr == 1'(b))) bank_nx[b] = FILL;
            // FULL only on the last write-back, so draining never reads unwritten rows.
            FILL:  if (row_ret && (tag_ret.bank == 1'(b)) && (tag_ret.idx == 3'd7))
                      bank_nx[b] = FULL;
            FULL:  if (col_issue && (rd_ptr == 1'(b))) bank_nx[b] = DRAIN;
            DRAIN: if (col_issue && (rd_ptr == 1'(b)) && (col_cnt == 3'd7))
                      bank_nx[b] = FREE;
            default: bank_nx[b] = bank_st[b];
         endcase
      end
   end

   // Control state: bank FSMs, ping-pong pointers, row/column counters, operand hold.
   always_ff @(posedge clk or negedge rst_n) begin : ctrl_regs
      // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
      if (!rst_n) begin
         bank_st[0] <= FREE;
         bank_st[1] <= FREE;
         wr_ptr     <= 1'b0;
         rd_ptr     <= 1'b0;
         row_cnt    <= 3'd0;
         col_cnt    <= 3'd0;
         eng_data_q <= '0;
      end else begin
         bank_st    <= bank_nx;
         eng_data_q <= eng_data;
         if (row_issue) begin
            row_cnt <= row_cnt + 3'd1;
            if (row_cnt == 3'd7) wr_ptr <= !wr_ptr;
         end
         if (col_issue) begin
            col_cnt <= col_cnt + 3'd1;
            if (col_cnt == 3'd7) rd_ptr <= !rd_ptr;
         end
      end
   end

   // Tag pipeline matching the engine latency; cleared so reset drops in-flight work.
   always_ff @(posedge clk or negedge rst_n) begin : tag_pipe
      if (!rst_n) begin
         tag_q <= '0;
      end else begin
         tag_q[0] <= tag_new;
         for (int k = 1; k < LAT; k++) begin
            tag_q[k] <= tag_q[k-1];
         end
      end
   end

   // Transpose store: row-pass results land here, block sof latched on the first row.
   always_ff @(posedge clk) begin : bank_store
      // NOTE: storage is not reset; bank FSMs gate every read, so stale contents are never observed.
      if (row_ret) begin
         mem[tag_ret.bank][tag_ret.idx] <= eng_res;
      end
      if (row_issue && (row_cnt == 3'd0)) begin
         bank_sof[wr_ptr] <= in_sof;
      end
   end

   // Registered coefficient column output, one cycle after the column result returns.
   always_ff @(posedge clk or negedge rst_n) begin : out_regs
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_sob   <= 1'b0;
         out_eob   <= 1'b0;
         out_sof   <= 1'b0;
         out_data  <= '0;
      end else begin
         out_valid <= col_ret;
         out_sob   <= col_ret && (tag_ret.idx == 3'd0);
         out_eob   <= col_ret && (tag_ret.idx == 3'd7);
         out_sof   <= col_ret && (tag_ret.idx == 3'd0) && tag_ret.sof;
         if (col_ret) out_data <= eng_res;
      end
   end

endmodule

// File: tb/tb_dct_pass_sched.sv
// tb_dct_pass_sched: directed bench for dct_pass_sched with an identity-delay
// engine model, so each output column is a column of the input block.
`timescale 1ns/1ps
module tb_dct_pass_sched;
   localparam int LAT = 8;
   localparam int W   = 16;

   typedef logic [7:0][W-1:0] vec_t;
   typedef struct {
      vec_t       data;
      logic [2:0] flags;   // {sob, eob, sof}
      int         cyc;
   } col_t;

   logic clk      = 1'b0;
   logic rst_n    = 1'b0;
   logic in_valid = 1'b0;
   logic in_sof   = 1'b0;
   vec_t in_data  = '0;
   logic in_ready, eng_valid, out_valid, out_sob, out_eob, out_sof;
   vec_t eng_data, eng_res, out_data;
   vec_t eng_pipe [LAT];

   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   col_t exp_q[$];
   col_t act_q[$];
   int   acc_cyc[$];
   int   first_col_cyc = -1;
   int   idle_flag_viol = 0;
   int   hold_viol = 0;
   vec_t last_eng_data = '0;
   logic last_rst = 1'b0;

   vec_t       blk_rows [32][8];
   logic [7:0] blk_sof_in [32];

   dct_pass_sched #(.LAT(LAT), .W(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_sof    (in_sof),
      .eng_valid (eng_valid),
      .eng_data  (eng_data),
      .eng_res   (eng_res),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_sob   (out_sob),
      .out_eob   (out_eob),
      .out_sof   (out_sof)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Identity engine: the operand comes back exactly LAT cycles after issue.
   always @(posedge clk) begin
      eng_pipe[0] <= eng_data;
      for (int k = 1; k < LAT; k++) eng_pipe[k] <= eng_pipe[k-1];
   end
   assign eng_res = eng_pipe[LAT-1];

   // Observe outputs mid-cycle, after the driver has settled this cycle's inputs.
   always begin
      @(negedge clk);
      #2;
      if (rst_n) begin
         if (out_valid)
            act_q.push_back('{data: out_data, flags: {out_sob, out_eob, out_sof}, cyc: cyc});
         else if (out_sob || out_eob || out_sof)
            idle_flag_viol++;
         if (in_valid && in_ready) acc_cyc.push_back(cyc);
         if (eng_valid && !(in_valid && in_ready) && first_col_cyc < 0) first_col_cyc = cyc;
         if (last_rst && !eng_valid && eng_data !== last_eng_data) hold_viol++;
      end
      last_eng_data = eng_data;
      last_rst      = rst_n;
   end

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Expected columns of block b: column j, element i = input row i, sample j.
   task automatic push_exp(input int b);
      col_t c;
      for (int j = 0; j < 8; j++) begin
         for (int i = 0; i < 8; i++) c.data[i] = blk_rows[b][i][j];
         c.flags = {j == 0, j == 7, (j == 0) && blk_sof_in[b][0]};
         c.cyc   = 0;
         exp_q.push_back(c);
      end
   endtask

   // Present nblk blocks starting at first_blk; optional random valid gaps.
   task automatic feed(input int first_blk, input int nblk, input bit gaps);
      int r     = 0;
      int guard = 0;
      while (r < nblk * 8 && guard < 4000) begin
         @(negedge clk);
         if (gaps && $urandom_range(1) == 0) begin
            in_valid = 1'b0;
         end else begin
            in_valid = 1'b1;
            in_data  = blk_rows[first_blk + r / 8][r % 8];
            in_sof   = blk_sof_in[first_blk + r / 8][r % 8];
         end
         #1;
         if (in_valid && in_ready) r++;
         guard++;
      end
      @(negedge clk);
      in_valid = 1'b0;
      check("feed_rows_accepted", r, nblk * 8);
   endtask

   task automatic wait_outputs(input int n);
      int guard = 0;
      while (act_q.size() < n && guard < 2000) begin
         @(negedge clk);
         guard++;
      end
   endtask

   task automatic compare_cols(input string tag);
      wait_outputs(exp_q.size());
      repeat (20) @(negedge clk);
      check({tag, "_count"}, act_q.size(), exp_q.size());
      for (int k = 0; k < exp_q.size() && k < act_q.size(); k++) begin
         check($sformatf("%s_data%0d", tag, k), act_q[k].data, exp_q[k].data);
         check($sformatf("%s_flags%0d", tag, k), act_q[k].flags, exp_q[k].flags);
      end
      act_q.delete();
      exp_q.delete();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int a0;
      int viol;
      int guard;

      // Block 0: sample s of row r = 8r+s, sof on row 0 only.
      for (int r = 0; r < 8; r++)
         for (int s = 0; s < 8; s++) blk_rows[0][r][s] = 16'(8 * r + s);
      blk_sof_in[0] = 8'h01;
      for (int b = 1; b < 32; b++) begin
         for (int r = 0; r < 8; r++)
            for (int s = 0; s < 8; s++) blk_rows[b][r][s] = 16'($urandom);
         blk_sof_in[b] = 8'($urandom);
      end
      blk_sof_in[1] = 8'h01;
      blk_sof_in[2] = 8'hfe;
      blk_sof_in[6] = 8'h01;

      // Reset state, including in_valid held high while in reset.
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_in_ready", in_ready, 1);
      check("rst_eng_valid", eng_valid, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_flags", {out_sob, out_eob, out_sof}, 0);
      in_valid = 1'b1;
      in_data  = blk_rows[1][0];
      #1;
      check("rst_eng_valid_with_in_valid", eng_valid, 0);
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Single block: transpose values and latency.
      first_col_cyc = -1;
      acc_cyc.delete();
      push_exp(0);
      feed(0, 1, 1'b0);
      wait_outputs(8);
      a0 = acc_cyc[0];
      check("lat_first_col_issue", first_col_cyc - a0, 16);
      check("lat_first_out", act_q[0].cyc - a0, 25);
      check("lat_cols_back_to_back", act_q[7].cyc - act_q[0].cyc, 7);
      check("single_col0_value", act_q[0].data[5], 16'd40);
      compare_cols("single");

      // Four blocks with in_valid held high: throughput, stalls, order.
      acc_cyc.delete();
      for (int b = 1; b <= 4; b++) push_exp(b);
      feed(1, 4, 1'b0);
      check("tput_accepts", acc_cyc.size(), 32);
      check("tput_first_two_blocks", acc_cyc[15] - acc_cyc[0], 15);
      check("tput_stall_both_busy", acc_cyc[16] - acc_cyc[15], 17);
      viol = 0;
      for (int k = 0; k < 16; k++)
         if (acc_cyc[k + 16] - acc_cyc[k] != 32) viol++;
      check("tput_period_32_per_16_rows", viol, 0);
      compare_cols("cont");

      // Reset pulsed during the column pass discards the block.
      first_col_cyc = -1;
      feed(5, 1, 1'b0);
      guard = 0;
      while (first_col_cyc < 0 && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      check("midrst_colpass_reached", first_col_cyc >= 0, 1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid_low", out_valid, 0);
      check("midrst_eng_valid_low", eng_valid, 0);
      act_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("midrst_in_ready_after", in_ready, 1);
      repeat (40) @(negedge clk);
      check("midrst_no_stale_output", act_q.size(), 0);
      push_exp(6);
      feed(6, 1, 1'b0);
      compare_cols("post_rst");

      // Twenty blocks with random valid gaps and random sof patterns.
      for (int b = 7; b < 27; b++) push_exp(b);
      feed(7, 20, 1'b1);
      compare_cols("gaps");

      check("idle_flags_zero", idle_flag_viol, 0);
      check("eng_data_held_idle", hold_viol, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
